reset_sequencer: RTL

Staged reset release controller sitting directly downstream of the reset synchroniser. It takes the synchronised system reset and releases up to NUM_STAGES downstream reset domains one at a time: LED matrix driver, audio, wishbone peripherals, CPU. Each release waits for the stage's ready acknowledge and then a settling delay. It supervises acknowledges with a timeout and supports a software-requested full re-sequence.

---
 rtl/reset_pkg.sv | 12 +
 rtl/reset_sequencer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/reset_pkg.sv
// reset_pkg: shared state encoding and sizing helpers for staged reset release
//   seq_state_t : sequencer FSM states (DELAY, WAIT_ACK, RUN, FAULT)
//   clog2_max   : bits needed to count from 0 up to max(a, b) inclusive
package reset_pkg;

    typedef enum logic [1:0] {DELAY, WAIT_ACK, RUN, FAULT} seq_state_t;

    function automatic int clog2_max(input int a, input int b);
        return $clog2((a > b ? a : b) + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases NUM_STAGES reset domains one at a time, each after a
// settling delay and the previous stage's acknowledge; supervises acks afterwards.
//   i_clk         system clock
//   i_rst_n       asynchronous active-low reset
//   i_sw_rst      level request to restart the whole sequence
//   i_stage_ack   per-stage ready acknowledge
//   o_stage_rst   active-high reset per stage, bit 0 released first
//   o_busy        sequence in progress
//   o_done        all stages released and acknowledged
//   o_fault       acknowledge timeout or acknowledge loss
//   o_fault_stage index of the stage that faulted
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int STAGE_DELAY = 16,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_sw_rst,
    input  logic [NUM_STAGES-1:0] i_stage_ack,
    output logic [NUM_STAGES-1:0] o_stage_rst,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_fault,
    output logic [(NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1)-1:0] o_fault_stage
);

    localparam int SW = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
    localparam int CW = clog2_max(STAGE_DELAY, ACK_TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STAGE_DELAY > ACK_TIMEOUT ? STAGE_DELAY : ACK_TIMEOUT);
    localparam logic [CW-1:0] DLY_LAST = CW'(STAGE_DELAY - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(ACK_TIMEOUT - 1);
    localparam logic [SW-1:0] K_LAST   = SW'(NUM_STAGES - 1);

    seq_state_t            state, state_nxt;
    logic [SW-1:0]         k, k_nxt, low, fault_idx, fs_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [NUM_STAGES-1:0] rst_nxt;
    logic                  busy_nxt, done_nxt, fault_nxt, go_fault;

    // Lowest-index dropped acknowledge, reported when supervision trips in RUN.
    always_comb begin
        low = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--)
            if (!i_stage_ack[i]) low = SW'(i);
    end

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        // The counter saturates so it can never wrap back into a terminal match.
        cnt_nxt   = cnt == CNT_MAX ? cnt : cnt + CW'(1);
        rst_nxt   = o_stage_rst;
        busy_nxt  = o_busy;
        done_nxt  = o_done;
        fault_nxt = o_fault;
        fs_nxt    = o_fault_stage;
        go_fault  = 1'b0;
        fault_idx = k;
        if (i_sw_rst) begin
            state_nxt = DELAY;
            k_nxt     = '0;
            cnt_nxt   = '0;
            rst_nxt   = '1;
            busy_nxt  = 1'b1;
            done_nxt  = 1'b0;
            fault_nxt = 1'b0;
        end else begin
            case (state)
                DELAY: if (cnt == DLY_LAST) begin
                    rst_nxt[k] = 1'b0;
                    state_nxt  = WAIT_ACK;
                    cnt_nxt    = '0;
                end
                // An ack sampled on the timeout edge wins over the fault.
                WAIT_ACK: if (i_stage_ack[k]) begin
                    cnt_nxt = '0;
                    if (k == K_LAST) begin
                        state_nxt = RUN;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                    end else begin
                        k_nxt     = k + SW'(1);
                        state_nxt = DELAY;
                    end
                end else if (cnt == TO_LAST) begin
                    go_fault = 1'b1;
                end
                RUN: if (!(&i_stage_ack)) begin
                    go_fault  = 1'b1;
                    fault_idx = low;
                end
                FAULT: ;
            endcase
            if (go_fault) begin
                state_nxt = FAULT;
                rst_nxt   = '1;
                fault_nxt = 1'b1;
                fs_nxt    = fault_idx;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= DELAY;
            k             <= '0;
            cnt           <= '0;
            o_stage_rst   <= '1;
            o_busy        <= 1'b1;
            o_done        <= 1'b0;
            o_fault       <= 1'b0;
            o_fault_stage <= '0;
        end else begin
            state         <= state_nxt;
            k             <= k_nxt;
            cnt           <= cnt_nxt;
            o_stage_rst   <= rst_nxt;
            o_busy        <= busy_nxt;
            o_done        <= done_nxt;
            o_fault       <= fault_nxt;
            o_fault_stage <= fs_nxt;
        end
    end

endmodule
